// File: rtl/part3_mac_pipe.sv
// part3_mac_pipe: pipelined signed multiply-accumulate with in-band clear, sticky overflow and optional saturation
//   clk       rising-edge clock
//   reset     asynchronous active-high reset, clears all state and in-flight samples
//   a, b      signed IN_W operands, sampled with valid_in
//   valid_in  a/b/clr valid this cycle
//   clr       sample starts a new accumulation (qualified by valid_in)
//   f         signed ACC_W accumulator value
//   valid_out f updated by a valid sample this cycle
//   ovf       sticky overflow flag for the current accumulation
//   Define MAC_SAT_EN to clamp f on overflow instead of wrapping.
module part3_mac_pipe #(
  parameter int IN_W      = 10,
  parameter int ACC_W     = 20,
  parameter int MULT_PIPE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic                    valid_in,
  input  logic                    clr,
  output logic signed [ACC_W-1:0] f,
  output logic                    valid_out,
  output logic                    ovf
);
  localparam int P_W = 2 * IN_W;
  // one product register always exists; MULT_PIPE adds stages behind it
  localparam int NP = MULT_PIPE + 1;

  if (ACC_W < P_W) begin : g_acc_chk
    $error("part3_mac_pipe: ACC_W must be >= 2*IN_W");
  end
  if (MULT_PIPE < 0 || MULT_PIPE > 2) begin : g_pipe_chk
    $error("part3_mac_pipe: MULT_PIPE must be 0..2");
  end

  logic signed [IN_W-1:0]  a_q, a_d, b_q, b_d;
  logic                    v0_q, v0_d, c0_q, c0_d;
  logic signed [P_W-1:0]   p_q [NP];
  logic signed [P_W-1:0]   p_d [NP];
  logic [NP-1:0]           pv_q, pv_d, pc_q, pc_d;
  logic signed [ACC_W-1:0] f_q, f_d, base, addend, sum, res;
  logic                    valid_out_q, valid_out_d, ovf_q, ovf_d, add_ovf;

  always_comb begin
    a_d = a;
    b_d = b;
    v0_d = valid_in;
    c0_d = clr;
    p_d[0] = P_W'(a_q) * P_W'(b_q);
    pv_d[0] = v0_q;
    pc_d[0] = c0_q;
    for (int i = 1; i < NP; i++) begin
      p_d[i] = p_q[i-1];
      pv_d[i] = pv_q[i-1];
      pc_d[i] = pc_q[i-1];
    end
  end

  // overflow: both addends share a sign that the truncated sum does not
  always_comb begin
    base = pc_q[NP-1] ? '0 : f_q;
    addend = ACC_W'(p_q[NP-1]);
    sum = base + addend;
    add_ovf = (base[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
`ifdef MAC_SAT_EN
    res = add_ovf ? (base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) : sum;
`else
    res = sum;
`endif
    f_d = pv_q[NP-1] ? res : f_q;
    valid_out_d = pv_q[NP-1];
    ovf_d = pv_q[NP-1] ? ((ovf_q & ~pc_q[NP-1]) | add_ovf) : ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      v0_q <= 1'b0;
      c0_q <= 1'b0;
      p_q <= '{default: '0};
      pv_q <= '0;
      pc_q <= '0;
      f_q <= '0;
      valid_out_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      v0_q <= v0_d;
      c0_q <= c0_d;
      p_q <= p_d;
      pv_q <= pv_d;
      pc_q <= pc_d;
      f_q <= f_d;
      valid_out_q <= valid_out_d;
      ovf_q <= ovf_d;
    end
  end

  assign f = f_q;
  assign valid_out = valid_out_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_part3_mac_pipe.sv
// tb_part3_mac_pipe: table-driven and scoreboard checks of part3_mac_pipe, default build plus MULT_PIPE sweep
module tb_part3_mac_pipe;
  typedef struct {
    bit v;
    logic signed [9:0] a, b;
    bit c;
    logic signed [19:0] f;
    bit o;
  } vec_t;
  typedef struct {
    logic signed [63:0] f;
    logic o;
    int cyc;
  } exp_t;

`ifdef MAC_SAT_EN
  localparam int OV2 = 524287, OV3 = 524287;
`else
  localparam int OV2 = -524288, OV3 = -262144;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic signed [9:0] a = '0, b = '0;
  logic valid_in = 1'b0, clr = 1'b0;
  logic signed [19:0] f;
  logic valid_out, ovf;
  logic signed [7:0] sa = '0, sb = '0;
  logic sv = 1'b0, sclr = 1'b0;

  int checks = 0, errors = 0, cyc = 0;
  exp_t mq[$];
  exp_t sq[3][$];
  vec_t tbl[$];
  logic signed [63:0] hold_f = 0;
  logic hold_o = 1'b0;
  longint msf = 0;
  bit movf = 1'b0;

  part3_mac_pipe dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clr(clr),
    .f(f), .valid_out(valid_out), .ovf(ovf)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(bit v, int ta, int tb, bit c, int ef, bit eo);
    vec_t t;
    t.v = v;
    t.a = 10'(ta);
    t.b = 10'(tb);
    t.c = c;
    t.f = 20'(ef);
    t.o = eo;
    return t;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      hold_f = 0;
      hold_o = 1'b0;
    end else if (valid_out) begin
      if (mq.size() == 0) chk("unexpected valid_out", valid_out, 0);
      else begin
        exp_t e;
        e = mq.pop_front();
        chk("f", f, e.f);
        chk("ovf", ovf, e.o);
        chk("latency", cyc, e.cyc);
        hold_f = e.f;
        hold_o = e.o;
      end
    end else begin
      chk("hold f", f, hold_f);
      chk("hold ovf", ovf, hold_o);
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_sw
    logic signed [23:0] sf;
    logic svo, sovf;
    logic signed [63:0] hf = 0;
    logic ho = 1'b0;
    part3_mac_pipe #(.IN_W(8), .ACC_W(24), .MULT_PIPE(g)) u_dut (
      .clk(clk), .reset(reset), .a(sa), .b(sb), .valid_in(sv), .clr(sclr),
      .f(sf), .valid_out(svo), .ovf(sovf)
    );
    always @(negedge clk) begin
      if (reset) begin
        hf = 0;
        ho = 1'b0;
      end else if (svo) begin
        if (sq[g].size() == 0) chk($sformatf("sweep%0d unexpected valid_out", g), svo, 0);
        else begin
          exp_t e;
          e = sq[g].pop_front();
          chk($sformatf("sweep%0d f", g), sf, e.f);
          chk($sformatf("sweep%0d ovf", g), sovf, e.o);
          chk($sformatf("sweep%0d latency", g), cyc, e.cyc);
          hf = e.f;
          ho = e.o;
        end
      end else begin
        chk($sformatf("sweep%0d hold f", g), sf, hf);
        chk($sformatf("sweep%0d hold ovf", g), sovf, ho);
      end
    end
  end

  task automatic drive_main(vec_t t, bit push);
    @(negedge clk);
    valid_in = t.v;
    a = t.a;
    b = t.b;
    clr = t.c;
    if (t.v && push) mq.push_back('{f: t.f, o: t.o, cyc: cyc + 4});
  endtask

  // golden model: exact integer sum, then range-check and wrap or clamp
  task automatic sweep_step(bit v, int ta, int tb, bit c);
    longint s;
    bit o;
    logic signed [23:0] w;
    @(negedge clk);
    sv = v;
    sa = 8'(ta);
    sb = 8'(tb);
    sclr = c;
    if (v) begin
      s = (c ? 64'sd0 : msf) + longint'(ta) * longint'(tb);
      o = (s > 8388607) || (s < -8388608);
`ifdef MAC_SAT_EN
      msf = (s > 8388607) ? 8388607 : (s < -8388608) ? -8388608 : s;
`else
      w = s[23:0];
      msf = w;
`endif
      movf = (c ? 1'b0 : movf) | o;
      for (int k = 0; k < 3; k++) sq[k].push_back('{f: msf, o: movf, cyc: cyc + 3 + k});
    end
  endtask

  task automatic drain();
    @(negedge clk);
    valid_in = 1'b0;
    clr = 1'b0;
    sv = 1'b0;
    sclr = 1'b0;
    for (int i = 0; i < 40 && (mq.size() + sq[0].size() + sq[1].size() + sq[2].size()) > 0; i++) @(negedge clk);
    chk("drain pending", mq.size() + sq[0].size() + sq[1].size() + sq[2].size(), 0);
  endtask

  initial begin
    tbl.push_back(mk(1, 3, 4, 1, 12, 0));
    tbl.push_back(mk(1, -2, 5, 0, 2, 0));
    tbl.push_back(mk(1, 7, -1, 0, -5, 0));
    tbl.push_back(mk(1, 3, 4, 1, 12, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, -2, 5, 0, 2, 0));
    tbl.push_back(mk(0, 9, 9, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 7, -1, 0, -5, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, -512, -512, 1, 262144, 0));
    tbl.push_back(mk(1, -512, -512, 0, OV2, 1));
    tbl.push_back(mk(1, -512, -512, 0, OV3, 1));
    tbl.push_back(mk(0, 5, 5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, -3, 3, 0, -8, 0));
    repeat (3) @(negedge clk);
    chk("reset f", f, 0);
    chk("reset valid_out", valid_out, 0);
    chk("reset ovf", ovf, 0);
    reset = 1'b0;
    foreach (tbl[i]) drive_main(tbl[i], 1'b1);
    drain();
    chk("pre-reset f", f, -8);
    drive_main(mk(1, 2, 3, 1, 0, 0), 1'b0);
    drive_main(mk(1, 4, 5, 0, 0, 0), 1'b0);
    drive_main(mk(1, 6, 7, 0, 0, 0), 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    valid_in = 1'b0;
    mq.delete();
    #1;
    chk("async reset f", f, 0);
    chk("async reset valid_out", valid_out, 0);
    chk("async reset ovf", ovf, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    sweep_step(1'b1, -128, -128, 1'b1);
    for (int i = 0; i < 700; i++)
      sweep_step(1'b1, -128 + int'($urandom_range(0, 10)), -128 + int'($urandom_range(0, 10)), 1'b0);
    for (int i = 0; i < 400; i++)
      sweep_step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128, $urandom_range(0, 9) == 0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
